// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch bus between the fetch-PC controller (master) and an SRAM-like slave.
// Handshake: a request transfers when inst_req and inst_addr_ok are both high on a clock edge;
// the slave returns exactly one inst_data_ok pulse with inst_rdata for each accepted request.
interface pc_fetch_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             inst_req;
    logic [WIDTH-1:0] inst_addr;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [WIDTH-1:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC controller: owns the architectural fetch PC, issues one outstanding instruction
// request at a time and hands {pc, instruction} to F/D under stall, redirect and misalignment.
module pc_fetch_ctrl #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hbfc00000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                exc_redirect,
    input  logic [WIDTH-1:0]    exc_target,
    input  logic                br_redirect,
    input  logic [WIDTH-1:0]    br_target,
    pc_fetch_ctrl_if.master     bus,
    output logic                valid_f,
    output logic [WIDTH-1:0]    pc_f,
    output logic [WIDTH-1:0]    inst_f,
    output logic                adel_f,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic             drop_q;
    logic             valid_q;
    logic [WIDTH-1:0] pc_f_q;
    logic [WIDTH-1:0] inst_f_q;
    logic             adel_q;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             aligned;

    assign redirect = exc_redirect | br_redirect;
    assign target   = exc_redirect ? exc_target : br_target;
    assign aligned  = (pc_q[1:0] == 2'b00);

    // A misaligned PC is never put on the bus; it is reported as AdEL from REQ instead.
    assign bus.inst_req  = (state_q == REQ) && aligned;
    assign bus.inst_addr = pc_q;

    assign valid_f = valid_q;
    assign pc_f    = pc_f_q;
    assign inst_f  = inst_f_q;
    assign adel_f  = adel_q;
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            drop_q   <= 1'b0;
            valid_q  <= 1'b0;
            pc_f_q   <= RESET_VECTOR;
            inst_f_q <= '0;
            adel_q   <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        pc_q <= target;
                        // Already-accepted request must still be drained, its data discarded.
                        if (bus.inst_addr_ok && aligned) begin
                            drop_q  <= 1'b1;
                            state_q <= WAIT;
                        end
                    end else if (!aligned) begin
                        pc_f_q   <= pc_q;
                        inst_f_q <= '0;
                        adel_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= HOLD;
                    end else if (bus.inst_addr_ok) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc_q <= target;
                        if (bus.inst_data_ok) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (bus.inst_data_ok) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            pc_f_q   <= pc_q;
                            inst_f_q <= bus.inst_rdata;
                            adel_q   <= 1'b0;
                            valid_q  <= 1'b1;
                            state_q  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= target;
                        state_q <= REQ;
                    end else if (!stall_i) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_f_q + WIDTH'(4);
                        state_q <= REQ;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed per-cycle vector table for pc_fetch_ctrl, followed by a zero-wait bus sequence
// that checks back-to-back deliveries and their spacing.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RV = 32'hbfc00000;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exc;
        logic [31:0] exc_t;
        logic        br;
        logic [31:0] br_t;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_adel;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        stall_i, exc_redirect, br_redirect;
    logic [31:0] exc_target, br_target;
    logic        valid_f, adel_f;
    logic [31:0] pc_f, inst_f;
    logic [1:0]  state_o;

    pc_fetch_ctrl_if #(.WIDTH(32)) bus ();

    pc_fetch_ctrl #(.WIDTH(32), .RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .bus          (bus),
        .valid_f      (valid_f),
        .pc_f         (pc_f),
        .inst_f       (inst_f),
        .adel_f       (adel_f),
        .state_o      (state_o)
    );

    vec_t tbl[64];
    int   n_tbl = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic rst_v, input logic stall_v, input logic exc_v, input logic [31:0] exc_tv,
                       input logic br_v, input logic [31:0] br_tv, input logic aok_v, input logic dok_v,
                       input logic [31:0] rdata_v, input logic e_req_v, input logic [31:0] e_addr_v,
                       input logic e_valid_v, input logic [31:0] e_pc_v, input logic [31:0] e_inst_v,
                       input logic e_adel_v);
        tbl[n_tbl] = '{rst_v, stall_v, exc_v, exc_tv, br_v, br_tv, aok_v, dok_v, rdata_v,
                       e_req_v, e_addr_v, e_valid_v, e_pc_v, e_inst_v, e_adel_v};
        n_tbl++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
            n_err++;
        end
    endtask

    // scoreboard for the hand-written zero-wait sequence: {pc, inst}
    logic [63:0] exp_q[$];

    initial begin
        logic        pend;
        logic [31:0] paddr;
        logic [63:0] e;
        int          last_cyc;

        rst = 1'b1; stall_i = 1'b0; exc_redirect = 1'b0; br_redirect = 1'b0;
        exc_target = '0; br_target = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;

        //   rst st  exc exc_t        br  br_t         aok dok rdata         req addr          val pc            inst          adel
        add(1, 0, 0, 0,            0, 0,            0, 0, 0,             0, RV,           0, RV,           0,            0);  // 0 reset
        add(1, 0, 0, 0,            0, 0,            0, 0, 0,             0, RV,           0, RV,           0,            0);  // 1
        add(0, 0, 0, 0,            0, 0,            0, 0, 0,             0, RV,           0, RV,           0,            0);  // 2 BOOT
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, RV,           0, RV,           0,            0);  // 3 REQ
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'h3c080001,  0, RV,           0, RV,           0,            0);  // 4 WAIT
        add(0, 1, 0, 0,            0, 0,            0, 0, 0,             0, RV,           1, RV,           32'h3c080001, 0);  // 5 HOLD stall
        add(0, 1, 0, 0,            0, 0,            0, 0, 0,             0, RV,           1, RV,           32'h3c080001, 0);  // 6
        add(0, 1, 0, 0,            0, 0,            0, 0, 0,             0, RV,           1, RV,           32'h3c080001, 0);  // 7
        add(0, 1, 0, 0,            0, 0,            0, 0, 0,             0, RV,           1, RV,           32'h3c080001, 0);  // 8
        add(0, 1, 0, 0,            0, 0,            0, 0, 0,             0, RV,           1, RV,           32'h3c080001, 0);  // 9
        add(0, 0, 0, 0,            0, 0,            0, 0, 0,             0, RV,           1, RV,           32'h3c080001, 0);  // 10 consume
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, RV+4,         0, RV,           32'h3c080001, 0);  // 11 REQ +4
        add(0, 0, 0, 0,            1, 32'hbfc00100, 0, 0, 0,             0, RV+4,         0, RV,           32'h3c080001, 0);  // 12 WAIT br
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'h12345678,  0, 32'hbfc00100, 0, RV,           32'h3c080001, 0);  // 13 drop
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, 32'hbfc00100, 0, RV,           32'h3c080001, 0);  // 14
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'h24020005,  0, 32'hbfc00100, 0, RV,           32'h3c080001, 0);  // 15
        add(0, 1, 1, 32'hbfc00380, 1, 32'hbfc00200, 0, 0, 0,             0, 32'hbfc00100, 1, 32'hbfc00100, 32'h24020005, 0);  // 16 exc+br
        add(0, 0, 0, 0,            1, 32'hbfc00102, 0, 0, 0,             1, 32'hbfc00380, 0, 32'hbfc00100, 32'h24020005, 0);  // 17
        add(0, 0, 0, 0,            0, 0,            0, 0, 0,             0, 32'hbfc00102, 0, 32'hbfc00100, 32'h24020005, 0);  // 18 AdEL
        add(0, 0, 0, 0,            1, 32'hfffffffc, 0, 0, 0,             0, 32'hbfc00102, 1, 32'hbfc00102, 0,            1);  // 19
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, 32'hfffffffc, 0, 32'hbfc00102, 0,            1);  // 20
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'h8c020010,  0, 32'hfffffffc, 0, 32'hbfc00102, 0,            1);  // 21
        add(0, 0, 0, 0,            0, 0,            0, 0, 0,             0, 32'hfffffffc, 1, 32'hfffffffc, 32'h8c020010, 0);  // 22 wrap
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, 32'h00000000, 0, 32'hfffffffc, 32'h8c020010, 0);  // 23
        add(1, 0, 0, 0,            0, 0,            0, 0, 0,             0, 32'h00000000, 0, 32'hfffffffc, 32'h8c020010, 0);  // 24 rst in WAIT
        add(0, 0, 0, 0,            1, 32'h00000100, 0, 0, 0,             0, RV,           0, RV,           0,            0);  // 25 BOOT ignores br
        add(0, 0, 0, 0,            1, 32'hbfc00040, 1, 0, 0,             1, RV,           0, RV,           0,            0);  // 26 br+aok
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'hdeadbeef,  0, 32'hbfc00040, 0, RV,           0,            0);  // 27 drop
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, 32'hbfc00040, 0, RV,           0,            0);  // 28
        add(0, 0, 0, 0,            0, 0,            0, 0, 0,             0, 32'hbfc00040, 0, RV,           0,            0);  // 29 slow slave
        add(0, 0, 0, 0,            1, 32'hbfc00080, 0, 1, 32'h11112222,  0, 32'hbfc00040, 0, RV,           0,            0);  // 30 br+dok
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, 32'hbfc00080, 0, RV,           0,            0);  // 31
        add(0, 0, 0, 0,            1, 32'hbfc000a0, 0, 0, 0,             0, 32'hbfc00080, 0, RV,           0,            0);  // 32
        add(0, 0, 0, 0,            1, 32'hbfc000c0, 0, 0, 0,             0, 32'hbfc000a0, 0, RV,           0,            0);  // 33 last wins
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'h00000055,  0, 32'hbfc000c0, 0, RV,           0,            0);  // 34
        add(0, 0, 0, 0,            0, 0,            1, 0, 0,             1, 32'hbfc000c0, 0, RV,           0,            0);  // 35
        add(0, 0, 0, 0,            0, 0,            0, 1, 32'h00000077,  0, 32'hbfc000c0, 0, RV,           0,            0);  // 36
        add(0, 1, 0, 0,            0, 0,            0, 0, 0,             0, 32'hbfc000c0, 1, 32'hbfc000c0, 32'h00000077, 0);  // 37

        // one reset edge before the table so its first row starts from a known state
        @(posedge clk);

        for (int i = 0; i < n_tbl; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; stall_i = tbl[i].stall;
            exc_redirect = tbl[i].exc; exc_target = tbl[i].exc_t;
            br_redirect = tbl[i].br; br_target = tbl[i].br_t;
            bus.inst_addr_ok = tbl[i].aok; bus.inst_data_ok = tbl[i].dok; bus.inst_rdata = tbl[i].rdata;
            #1;
            n_vec++;
            chk("inst_req",  i, {31'd0, bus.inst_req}, {31'd0, tbl[i].e_req});
            chk("inst_addr", i, bus.inst_addr,         tbl[i].e_addr);
            chk("valid_f",   i, {31'd0, valid_f},      {31'd0, tbl[i].e_valid});
            chk("pc_f",      i, pc_f,                  tbl[i].e_pc);
            chk("inst_f",    i, inst_f,                tbl[i].e_inst);
            chk("adel_f",    i, {31'd0, adel_f},       {31'd0, tbl[i].e_adel});
        end

        // zero-wait slave, no stall: consecutive deliveries exactly 3 cycles apart
        exp_q.push_back({32'hbfc000c0, 32'h00000077});
        for (int k = 1; k <= 3; k++) begin
            paddr = 32'hbfc000c0 + 32'(4 * k);
            exp_q.push_back({paddr, ~paddr});
        end
        pend = 1'b0; paddr = '0; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            stall_i = 1'b0; br_redirect = 1'b0; exc_redirect = 1'b0; rst = 1'b0;
            #1;
            if (valid_f) begin
                e = exp_q.pop_front();
                n_vec++;
                chk("seq_pc",   cyc, pc_f,            e[63:32]);
                chk("seq_inst", cyc, inst_f,          e[31:0]);
                chk("seq_adel", cyc, {31'd0, adel_f}, 32'd0);
                if (last_cyc >= 0) chk("seq_spacing", cyc, 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
            end
            bus.inst_data_ok = pend;
            bus.inst_rdata   = pend ? ~paddr : 32'd0;
            bus.inst_addr_ok = bus.inst_req;
            pend             = bus.inst_req;
            if (bus.inst_req) paddr = bus.inst_addr;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL seq_timeout: %0d deliveries missing, expected 0", exp_q.size());
            n_err++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
